mem_ctrl: RTL and testbench

- Byte-serial memory controller between the load/store unit and the 8-bit synchronous RAM/IO bus.
- Converts one byte, half or word load/store request into consecutive single-byte bus cycles.
- Assembles load bytes little-endian into a zero-extended 32-bit value.
- Hands that value and the size flags to the downstream load-extension stage, which applies sign extension.

---
 rtl/mem_ctrl_pkg.sv | 40 ++++
 rtl/mem_ctrl_byte_assembler.sv | 36 +++
 rtl/mem_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared widths, state encoding and size decode for mem_ctrl.
// Optional IO write stall is enabled by MEM_IO_STALL_EN.
package mem_ctrl_pkg;

  localparam int REG_W  = 32;
  localparam int ADDR_W = 32;
  localparam int BYTE_W = 8;

  localparam logic [31:0] IO_BASE_DEF = 32'h0003_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  typedef logic [2:0] cnt_t;

  typedef struct packed {
    logic w;
    logic h;
    logic b;
  } size_t;

  function automatic cnt_t size_bytes(
    input logic w,
    input logic h,
    input logic b
  );
    cnt_t n;
    priority case (1'b1)
      w:       n = 3'd4;
      h:       n = 3'd2;
      b:       n = 3'd1;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_ctrl_byte_assembler.sv
// Four-lane load capture register; data_o shows the lane being
// written this cycle so the final byte can be registered downstream.
module mem_ctrl_byte_assembler
  import mem_ctrl_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              en_in,
  input  logic              clr_in,
  input  logic              wr_in,
  input  logic [1:0]        lane_in,
  input  logic [BYTE_W-1:0] din_in,
  output logic [REG_W-1:0]  data_o
);

  logic [3:0][BYTE_W-1:0] lanes_q;
  logic [3:0][BYTE_W-1:0] lanes_d;

  always_comb begin
    lanes_d = lanes_q;
    if (clr_in)
      lanes_d = '0;
    else if (wr_in)
      lanes_d[lane_in] = din_in;
  end

  assign data_o = lanes_d;

  always_ff @(posedge clk_in) begin
    if (rst_in)
      lanes_q <= '0;
    else if (en_in)
      lanes_q <= lanes_d;
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial load/store controller for the 8-bit RAM/IO bus.
// MEM_IO_STALL_EN holds IO-region store bytes while io_buffer_full.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = REG_W,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE =
    ADDR_WIDTH'(IO_BASE_DEF)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic                  req_is_byte,
  input  logic                  req_is_half,
  input  logic                  req_is_word,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_is_byte,
  output logic                  resp_is_half,
  output logic                  resp_is_word,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [7:0]            mem_dout,
  output logic                  mem_wr,
  input  logic [7:0]            mem_din,
  input  logic                  io_buffer_full
);

  state_e                state_q, state_d;
  cnt_t                  cnt_q, cnt_d;
  cnt_t                  n_q, n_d;
  logic [REG_W-1:0]      wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  size_t                 rsz_q, rsz_d;

  cnt_t                  req_n;
  logic                  io_stall;
  logic                  asm_clr;
  logic                  asm_wr;
  logic [1:0]            asm_lane;
  logic [REG_W-1:0]      asm_data;

  assign req_n = size_bytes(req_is_word, req_is_half,
                            req_is_byte);

`ifdef MEM_IO_STALL_EN
  assign io_stall = mem_wr_q & io_buffer_full &
                    (mem_a_q >= IO_BASE);
`else
  logic unused_io;
  assign unused_io = io_buffer_full;
  assign io_stall  = 1'b0;
`endif

  // byte k arrives two edges after its address was issued
  assign asm_lane = cnt_q[1:0] - 2'd2;

  mem_ctrl_byte_assembler u_asm (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .en_in   (rdy_in),
    .clr_in  (asm_clr),
    .wr_in   (asm_wr),
    .lane_in (asm_lane),
    .din_in  (mem_din),
    .data_o  (asm_data)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    n_d          = n_q;
    wdata_d      = wdata_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = mem_wr_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    rsz_d        = rsz_q;
    asm_clr      = 1'b0;
    asm_wr       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          rsz_d       = {req_is_word, req_is_half,
                         req_is_byte};
          n_d         = req_n;
          wdata_d     = REG_W'(req_wdata);
          cnt_d       = 3'd1;
          resp_data_d = '0;
          asm_clr     = 1'b1;
          if (req_n == 3'd0) begin
            state_d = ST_WRITE;
          end else if (req_wr) begin
            state_d    = ST_WRITE;
            mem_a_d    = req_addr;
            mem_dout_d = req_wdata[7:0];
            mem_wr_d   = 1'b1;
          end else begin
            state_d = ST_READ;
            mem_a_d = req_addr;
          end
        end
      end
      ST_READ: begin
        asm_wr = (cnt_q >= 3'd2);
        if (cnt_q < n_q)
          mem_a_d = mem_a_q + ADDR_WIDTH'(1);
        if (cnt_q == n_q + 3'd1) begin
          state_d      = ST_IDLE;
          cnt_d        = '0;
          resp_valid_d = 1'b1;
          resp_data_d  = DATA_WIDTH'(asm_data);
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_WRITE: begin
        if (!io_stall) begin
          if (cnt_q < n_q) begin
            mem_a_d    = mem_a_q + ADDR_WIDTH'(1);
            mem_dout_d =
              wdata_q[{cnt_q[1:0], 3'b000} +: BYTE_W];
            mem_wr_d   = 1'b1;
            cnt_d      = cnt_q + 3'd1;
          end else begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            mem_wr_d     = 1'b0;
            resp_valid_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      n_q          <= '0;
      wdata_q      <= '0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      rsz_q        <= '0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      n_q          <= n_d;
      wdata_q      <= wdata_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      rsz_q        <= rsz_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign resp_is_byte = rsz_q.b;
  assign resp_is_half = rsz_q.h;
  assign resp_is_word = rsz_q.w;
  assign mem_a        = mem_a_q;
  assign mem_dout     = mem_dout_q;
  assign mem_wr       = mem_wr_q & rdy_in & ~io_stall;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl with a registered-read byte RAM.
// Build with MEM_IO_STALL_EN to exercise the IO write stall.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_is_byte = 1'b0;
  logic        req_is_half = 1'b0;
  logic        req_is_word = 1'b0;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_is_byte;
  logic        resp_is_half;
  logic        resp_is_word;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din = '0;
  logic        io_buffer_full = 1'b0;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_wr         (req_wr),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_is_byte    (req_is_byte),
    .req_is_half    (req_is_half),
    .req_is_word    (req_is_word),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .resp_is_byte   (resp_is_byte),
    .resp_is_half   (resp_is_half),
    .resp_is_word   (resp_is_word),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full)
  );

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
    int          c;
  } wr_t;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  sz;
    int          lat;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          wbase = 0;
  logic        stall_wr = 1'b0;
  logic        io_wr = 1'b0;
  wr_t         wlog[$];
  exp_t        sb[$];
  logic [31:0] atrace[$];
  logic [7:0]  init_ram [256];

  function automatic logic [7:0] rd(input logic [31:0] a);
    for (int i = wlog.size() - 1; i >= 0; i--)
      if (wlog[i].a == a) return wlog[i].d;
    return init_ram[a[7:0]];
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_din <= rd(mem_a);
    if (mem_wr)
      wlog.push_back('{a: mem_a, d: mem_dout, c: cyc});
  end

  task automatic issue(
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic [2:0]  sz,
    input  int          st_at,
    input  int          st_len,
    input  int          io_len,
    output int          lat,
    output logic [31:0] data,
    output logic [2:0]  flags
  );
    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wd;
    {req_is_word, req_is_half, req_is_byte} = sz;
    io_buffer_full = (io_len > 0);
    wbase    = wlog.size();
    stall_wr = 1'b0;
    io_wr    = 1'b0;
    atrace.delete();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    atrace.push_back(mem_a);
    if (io_buffer_full && mem_wr) io_wr = 1'b1;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      rdy_in = !(lat >= st_at && lat < st_at + st_len);
      io_buffer_full = (lat < io_len);
      @(posedge clk);
      #1;
      lat++;
      atrace.push_back(mem_a);
      if (!rdy_in && mem_wr) stall_wr = 1'b1;
      if (io_buffer_full && mem_wr) io_wr = 1'b1;
    end
    if (!resp_valid) lat = -1;
    data  = resp_data;
    flags = {resp_is_word, resp_is_half, resp_is_byte};
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b want=1", req_ready);
    end
    checks++;
    if (mem_a !== 32'h0 || mem_dout !== 8'h0) begin
      failures++;
      $display("FAIL reset_bus got a=%h d=%h want 0/0",
               mem_a, mem_dout);
    end
    checks++;
    if (mem_wr !== 1'b0 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_strobes got wr=%b rv=%b want 0/0",
               mem_wr, resp_valid);
    end
    checks++;
    if (resp_data !== 32'h0 ||
        {resp_is_word, resp_is_half, resp_is_byte} !== 3'b000)
    begin
      failures++;
      $display("FAIL reset_resp got d=%h sz=%b want 0/000",
               resp_data,
               {resp_is_word, resp_is_half, resp_is_byte});
    end
    rst_in = 1'b0;
  endtask

  task automatic test_word_load();
    exp_t        e;
    int          lat;
    logic [31:0] d;
    logic [2:0]  f;
    init_ram[8'h00] = 8'h11;
    init_ram[8'h01] = 8'h22;
    init_ram[8'h02] = 8'h33;
    init_ram[8'h03] = 8'h44;
    sb.push_back('{data: 32'h4433_2211, sz: 3'b100, lat: 5});
    issue(1'b0, 32'h1000, 32'h0, 3'b100, 0, 0, 0, lat, d, f);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin
      failures++;
      $display("FAIL wload_lat got=%0d want=%0d", lat, e.lat);
    end
    checks++;
    if (d !== e.data || f !== e.sz) begin
      failures++;
      $display("FAIL wload_data got=%h/%b want=%h/%b",
               d, f, e.data, e.sz);
    end
    checks++;
    if (wlog.size() - wbase !== 0) begin
      failures++;
      $display("FAIL wload_nowr got=%0d writes want=0",
               wlog.size() - wbase);
    end
    checks++;
    if (atrace.size() < 4 || atrace[3] !== 32'h1003) begin
      failures++;
      $display("FAIL wload_addr got=%0d entries want a3=1003",
               atrace.size());
    end
    @(posedge clk);
    #1;
    checks++;
    if (resp_valid !== 1'b0 || resp_is_word !== 1'b1) begin
      failures++;
      $display("FAIL wload_pulse got rv=%b w=%b want 0/1",
               resp_valid, resp_is_word);
    end
  endtask

  task automatic test_half_store();
    exp_t        e;
    int          lat;
    logic [31:0] d;
    logic [2:0]  f;
    init_ram[8'h01] = 8'h5A;
    sb.push_back('{data: 32'h0, sz: 3'b010, lat: 2});
    issue(1'b1, 32'h2FFF, 32'hAABB_CCDD, 3'b010, 0, 0, 0,
          lat, d, f);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || d !== e.data || f !== e.sz) begin
      failures++;
      $display("FAIL hstore_resp got=%0d/%h/%b want=%0d/%h/%b",
               lat, d, f, e.lat, e.data, e.sz);
    end
    checks++;
    if (wlog.size() - wbase !== 2) begin
      failures++;
      $display("FAIL hstore_count got=%0d want=2",
               wlog.size() - wbase);
    end else begin
      checks++;
      if (wlog[wbase].a !== 32'h2FFF ||
          wlog[wbase].d !== 8'hDD ||
          wlog[wbase+1].a !== 32'h3000 ||
          wlog[wbase+1].d !== 8'hCC ||
          wlog[wbase+1].c - wlog[wbase].c !== 1) begin
        failures++;
        $display("FAIL hstore_bytes got %h=%h %h=%h want 2fff=dd 3000=cc",
                 wlog[wbase].a, wlog[wbase].d,
                 wlog[wbase+1].a, wlog[wbase+1].d);
      end
    end
    checks++;
    if (rd(32'h3001) !== 8'h5A) begin
      failures++;
      $display("FAIL hstore_keep got=%h want=5a", rd(32'h3001));
    end
  endtask

  task automatic test_wrap();
    exp_t        e;
    int          lat;
    logic [31:0] d;
    logic [2:0]  f;
    init_ram[8'hFF] = 8'h80;
    sb.push_back('{data: 32'h0000_0080, sz: 3'b001, lat: 2});
    issue(1'b0, 32'hFFFF_FFFF, 32'h0, 3'b001, 0, 0, 0,
          lat, d, f);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || d !== e.data || f !== e.sz) begin
      failures++;
      $display("FAIL bload_resp got=%0d/%h/%b want=%0d/%h/%b",
               lat, d, f, e.lat, e.data, e.sz);
    end
    init_ram[8'hFE] = 8'hA1;
    init_ram[8'hFF] = 8'hB2;
    init_ram[8'h00] = 8'hC3;
    init_ram[8'h01] = 8'hD4;
    sb.push_back('{data: 32'hD4C3_B2A1, sz: 3'b100, lat: 5});
    issue(1'b0, 32'hFFFF_FFFE, 32'h0, 3'b100, 0, 0, 0,
          lat, d, f);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || d !== e.data || f !== e.sz) begin
      failures++;
      $display("FAIL wrap_resp got=%0d/%h/%b want=%0d/%h/%b",
               lat, d, f, e.lat, e.data, e.sz);
    end
    checks++;
    if (atrace.size() < 4 ||
        atrace[0] !== 32'hFFFF_FFFE ||
        atrace[1] !== 32'hFFFF_FFFF ||
        atrace[2] !== 32'h0 || atrace[3] !== 32'h1) begin
      failures++;
      $display("FAIL wrap_addr got=%0d entries want fffffffe..1",
               atrace.size());
    end
  endtask

  task automatic test_rdy_stall();
    exp_t        e;
    int          lat;
    logic [31:0] d;
    logic [2:0]  f;
    logic [31:0] wd;
    wd = 32'h1122_3344;
    sb.push_back('{data: 32'h0, sz: 3'b100, lat: 7});
    issue(1'b1, 32'h0500, wd, 3'b100, 1, 3, 0, lat, d, f);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || f !== e.sz) begin
      failures++;
      $display("FAIL stall_lat got=%0d/%b want=%0d/%b",
               lat, f, e.lat, e.sz);
    end
    checks++;
    if (stall_wr !== 1'b0) begin
      failures++;
      $display("FAIL stall_wr got=%b want=0", stall_wr);
    end
    checks++;
    if (wlog.size() - wbase !== 4) begin
      failures++;
      $display("FAIL stall_count got=%0d want=4",
               wlog.size() - wbase);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (wlog[wbase+k].a !== 32'h0500 + k ||
            wlog[wbase+k].d !== wd[8*k +: 8]) begin
          failures++;
          $display("FAIL stall_byte%0d got %h=%h want %h=%h", k,
                   wlog[wbase+k].a, wlog[wbase+k].d,
                   32'h0500 + k, wd[8*k +: 8]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t        e;
    int          lat;
    int          rv;
    logic [31:0] d;
    logic [2:0]  f;
    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = 1'b0;
    req_addr  = 32'h1000;
    {req_is_word, req_is_half, req_is_byte} = 3'b100;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_in = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || mem_wr !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_idle got rdy=%b wr=%b want 1/0",
               req_ready, mem_wr);
    end
    @(negedge clk);
    rst_in = 1'b0;
    rv = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (resp_valid) rv++;
    end
    checks++;
    if (rv !== 0) begin
      failures++;
      $display("FAIL rstmid_noresp got=%0d want=0", rv);
    end
    init_ram[8'h00] = 8'h77;
    sb.push_back('{data: 32'h0000_0077, sz: 3'b001, lat: 2});
    issue(1'b0, 32'h1000, 32'h0, 3'b001, 0, 0, 0, lat, d, f);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || d !== e.data || f !== e.sz) begin
      failures++;
      $display("FAIL rstmid_after got=%0d/%h/%b want=%0d/%h/%b",
               lat, d, f, e.lat, e.data, e.sz);
    end
  endtask

  task automatic test_io_stall();
    exp_t        e;
    int          lat;
    logic [31:0] d;
    logic [2:0]  f;
    logic        exp_io_wr;
`ifdef MEM_IO_STALL_EN
    sb.push_back('{data: 32'h0, sz: 3'b001, lat: 5});
    exp_io_wr = 1'b0;
`else
    sb.push_back('{data: 32'h0, sz: 3'b001, lat: 1});
    exp_io_wr = 1'b1;
`endif
    issue(1'b1, 32'h0003_0000, 32'h0000_005C, 3'b001, 0, 0, 4,
          lat, d, f);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || f !== e.sz) begin
      failures++;
      $display("FAIL io_lat got=%0d/%b want=%0d/%b",
               lat, f, e.lat, e.sz);
    end
    checks++;
    if (io_wr !== exp_io_wr) begin
      failures++;
      $display("FAIL io_wr_while_full got=%b want=%b",
               io_wr, exp_io_wr);
    end
    checks++;
    if (wlog.size() - wbase !== 1 ||
        wlog[wbase].a !== 32'h0003_0000 ||
        wlog[wbase].d !== 8'h5C) begin
      failures++;
      $display("FAIL io_write got=%0d writes want one 30000=5c",
               wlog.size() - wbase);
    end
    io_buffer_full = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    int          lat;
    logic [31:0] d;
    logic [2:0]  f;
    sb.push_back('{data: 32'h0, sz: 3'b000, lat: 1});
    issue(1'b0, 32'h1000, 32'h0, 3'b000, 0, 0, 0, lat, d, f);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || d !== e.data || f !== e.sz) begin
      failures++;
      $display("FAIL nosize_resp got=%0d/%h/%b want=%0d/%h/%b",
               lat, d, f, e.lat, e.data, e.sz);
    end
    checks++;
    if (req_ready !== 1'b1 || wlog.size() - wbase !== 0) begin
      failures++;
      $display("FAIL b2b_ready got rdy=%b writes=%0d want 1/0",
               req_ready, wlog.size() - wbase);
    end
    init_ram[8'h00] = 8'hEE;
    init_ram[8'h01] = 8'hFF;
    sb.push_back('{data: 32'h0000_FFEE, sz: 3'b010, lat: 3});
    issue(1'b0, 32'h1000, 32'h0, 3'b010, 0, 0, 0, lat, d, f);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || d !== e.data || f !== e.sz) begin
      failures++;
      $display("FAIL b2b_half got=%0d/%h/%b want=%0d/%h/%b",
               lat, d, f, e.lat, e.data, e.sz);
    end
    sb.push_back('{data: 32'h0, sz: 3'b001, lat: 1});
    issue(1'b1, 32'h0700, 32'h0000_00A5, 3'b011, 0, 0, 0,
          lat, d, f);
    e = sb.pop_front();
    checks++;
    if (lat !== 2 || f !== 3'b011 ||
        wlog.size() - wbase !== 2 ||
        wlog[wbase+1].d !== 8'h00) begin
      failures++;
      $display("FAIL b2b_prio got=%0d/%b want=2/011 half",
               lat, f);
    end
    e.lat = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) init_ram[i] = 8'h00;
    test_reset();
    test_word_load();
    test_half_store();
    test_wrap();
    test_rdy_stall();
    test_reset_mid();
    test_io_stall();
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
